// File: rtl/wm_pkg.sv
// Washing-machine controller state encodings, shared by the controller and
// the phase timer.
package wm_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_START      = 3'd0;
  localparam logic [STATE_W-1:0] ST_READY      = 3'd1;
  localparam logic [STATE_W-1:0] ST_FILL_WATER = 3'd2;
  localparam logic [STATE_W-1:0] ST_HEAT_WATER = 3'd3;
  localparam logic [STATE_W-1:0] ST_WASH       = 3'd4;
  localparam logic [STATE_W-1:0] ST_RINSE      = 3'd5;
  localparam logic [STATE_W-1:0] ST_SPIN       = 3'd6;
  localparam logic [STATE_W-1:0] ST_FAULT      = 3'd7;

  // Phases that end normally with sig_Completed.
  function automatic logic is_run_phase(input logic [STATE_W-1:0] s);
    return (s == ST_WASH) || (s == ST_RINSE) || (s == ST_SPIN);
  endfunction

  // Phases supervised for overrun with sig_Time_Out.
  function automatic logic is_sup_phase(input logic [STATE_W-1:0] s);
    return (s == ST_FILL_WATER) || (s == ST_HEAT_WATER);
  endfunction

endpackage

// File: rtl/wm_phase_counter.sv
// Phase cycle counter: counts up while enabled until count == limit-1, then
// sets done, emits a one-cycle tick and freezes until cleared.
// The limit is one bit wider than the count so a limit of 2^CNT_W fits.
module wm_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W:0]   limit,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             tick
);

  logic [CNT_W:0] last;

  assign last = limit - (CNT_W+1)'(1);

  // Count, terminal detect and tick; clear has priority over counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (clear) begin
        count <= '0;
        done  <= 1'b0;
      end else if (enable && !done) begin
        if ({1'b0, count} == last) begin
          done <= 1'b1;
          tick <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/wm_phase_timer.sv
// Phase timer for the washing-machine controller: restarts on every state
// change, times the current phase and raises sig_Completed or sig_Time_Out
// once per phase visit.
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int WASH_CYCLES  = 1000,
  parameter int RINSE_CYCLES = 600,
  parameter int SPIN_CYCLES  = 400,
  parameter int FILL_TIMEOUT = 2000,
  parameter int HEAT_TIMEOUT = 3000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [STATE_W-1:0] state,
  output logic               sig_Completed,
  output logic               sig_Time_Out,
  output logic [CNT_W-1:0]   elapsed,
  output logic               expired
);

  logic [STATE_W-1:0] prev_state;
  logic               entry;
  logic               timed;
  logic [CNT_W:0]     limit;
  logic               tick;

  // Previous state, used to spot phase entry.
  always_ff @(posedge clock) begin
    if (reset) prev_state <= ST_START;
    else       prev_state <= state;
  end

  assign entry = (state != prev_state);
  assign timed = is_run_phase(state) || is_sup_phase(state);

  // Limit for the phase currently shown on state.
  always_comb begin
    limit = (CNT_W+1)'(1);
    case (state)
      ST_WASH:       limit = (CNT_W+1)'(WASH_CYCLES);
      ST_RINSE:      limit = (CNT_W+1)'(RINSE_CYCLES);
      ST_SPIN:       limit = (CNT_W+1)'(SPIN_CYCLES);
      ST_FILL_WATER: limit = (CNT_W+1)'(FILL_TIMEOUT);
      ST_HEAT_WATER: limit = (CNT_W+1)'(HEAT_TIMEOUT);
      default:       limit = (CNT_W+1)'(1);
    endcase
  end

  wm_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (entry),
    .enable (timed && !entry),
    .limit  (limit),
    .count  (elapsed),
    .done   (expired),
    .tick   (tick)
  );

  // The tick is registered, so the phase that produced it is the one now in
  // prev_state; routing on it keeps the pulse with its phase even when
  // state moves on in the pulse cycle.
  assign sig_Completed = tick && is_run_phase(prev_state);
  assign sig_Time_Out  = tick && is_sup_phase(prev_state);

endmodule

// File: tb/tb_wm_phase_timer.sv
// Bench for wm_phase_timer: expected pulses are queued when a phase is
// entered and matched cycle by cycle; elapsed/expired follow the phase timing.
module tb_wm_phase_timer;

  localparam int CNT_W = 8;
  localparam int WASH  = 5;
  localparam int RINSE = 3;
  localparam int SPIN  = 4;
  localparam int FILL  = 6;
  localparam int HEAT  = 7;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       state = 3'd0;
  logic             sig_Completed;
  logic             sig_Time_Out;
  logic [CNT_W-1:0] elapsed;
  logic             expired;

  always #5 clock = ~clock;

  wm_phase_timer #(
    .CNT_W(CNT_W), .WASH_CYCLES(WASH), .RINSE_CYCLES(RINSE),
    .SPIN_CYCLES(SPIN), .FILL_TIMEOUT(FILL), .HEAT_TIMEOUT(HEAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .state         (state),
    .sig_Completed (sig_Completed),
    .sig_Time_Out  (sig_Time_Out),
    .elapsed       (elapsed),
    .expired       (expired)
  );

  typedef struct {
    int         at;
    logic [1:0] p;   // {sig_Completed, sig_Time_Out}
  } ev_t;

  ev_t q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int m_e = 0, m_l = 0, o_e = 0, o_l = 0, chg = -1;
  bit m_t = 1'b0, o_t = 1'b0, mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int lim(input logic [2:0] s);
    case (s)
      3'd2:    return FILL;
      3'd3:    return HEAT;
      3'd4:    return WASH;
      3'd5:    return RINSE;
      3'd6:    return SPIN;
      default: return 0;
    endcase
  endfunction

  // New phase seen by the DUT from cycle e. A pulse due in the entry cycle
  // itself is already registered and survives a plain state change; a
  // reset released at e wipes anything from e on.
  task automatic enter(input logic [2:0] s, input int e, input bit from_reset);
    ev_t ev;
    int  keep_to;
    o_e = m_e; o_l = m_l; o_t = from_reset ? 1'b0 : m_t; chg = e;
    m_e = e; m_l = lim(s); m_t = (m_l != 0);
    keep_to = from_reset ? e - 1 : e;
    while (q.size() > 0 && q[$].at > keep_to) void'(q.pop_back());
    if (m_t) begin
      ev.at = e + m_l + 1;
      ev.p  = (s >= 3'd4) ? 2'b10 : 2'b01;
      q.push_back(ev);
    end
  endtask

  task automatic set_state(input logic [2:0] s, input int n);
    @(posedge clock); #1;
    if (s !== state) enter(s, cyc, 1'b0);
    state = s;
    repeat (n - 1) @(posedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    enter(state, cyc, 1'b1);
  endtask

  // Per-cycle comparison of pulses against the queue and of elapsed/expired
  // against the phase timing (cnt = k at E+1+k, done from E+LIMIT+1).
  always @(negedge clock) begin
    logic [1:0] ep;
    int e, l, d;
    bit t, ex;
    if (mon_en) begin
      ep = 2'b00;
      if (q.size() > 0 && q[0].at == cyc) begin
        ep = q[0].p;
        void'(q.pop_front());
      end
      if (cyc == chg) begin e = o_e; l = o_l; t = o_t; end
      else            begin e = m_e; l = m_l; t = m_t; end
      if (t) begin
        d = cyc - e - 1;
        if (d < 0)     d = 0;
        if (d > l - 1) d = l - 1;
        ex = (cyc >= e + l + 1);
      end else begin
        d  = 0;
        ex = 1'b0;
      end
      chk("pulse",   {30'd0, sig_Completed, sig_Time_Out}, {30'd0, ep});
      chk("elapsed", {24'd0, elapsed}, d);
      chk("expired", {31'd0, expired}, {31'd0, ex});
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(posedge clock); #1 mon_en = 1'b1;
    repeat (19) @(posedge clock);
    #1 reset = 1'b0;
    set_state(3'd0, 3);
    set_state(3'd4, 27);   // wash, then 20+ quiet cycles after the pulse
    set_state(3'd2, 12);   // fill timeout
    set_state(3'd5, 4);    // rinse, leaves on its own pulse cycle
    set_state(3'd6, 10);   // spin
    set_state(3'd3, 4);    // heat, reset when cnt = 3
    do_reset();
    set_state(3'd3, 12);
    set_state(3'd4, 3);    // aborted wash
    set_state(3'd7, 2);
    set_state(3'd4, 10);   // fresh wash
    set_state(3'd1, 5);
    @(negedge clock); #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
